vdp_ctrl: RTL and testbench
===========================

# vdp_ctrl

CPU-side controller for the MSX video subsystem. Decodes TMS9918-style data/control port accesses, holds VDP registers R0–R7 and the status flag, and sequences all CPU traffic into VRAM port A. Provides auto-increment addressing and a read-ahead buffer. Drives the video block's configuration inputs (`mode`, `name_table_addr`, `font_addr`, `video_on`) and the CPU interrupt.

## Interface
Parameters:
- `ADDR_W`, 14: VRAM address width.

Ports:
- `clk` in 1: system clock, the same clock as VRAM port A.
- `reset` in 1: synchronous, active-low reset.
- `cpu_wr` in 1: one-cycle write strobe.
- `cpu_rd` in 1: one-cycle read strobe.
- `cpu_port` in 1: 0 = data port (0x98), 1 = control port (0x99).
- `cpu_din` in 8: CPU write data.
- `cpu_dout` out 8: registered CPU read data.
- `busy` out 1: high while a VRAM sequence is in progress.
- `vram_addr` out 14, `vram_din` out 8, `vram_wr` out 1, `vram_rd` out 1: VRAM port A request.
- `vram_dout` in 8: VRAM read data, valid 1 cycle after `vram_rd`.
- `frame_int` in 1: vblank indication from the video block, edge-detected.
- `mode` out 2, `name_table_addr` out 14, `font_addr` out 14, `video_on` out 1: video block configuration.
- `n_int` out 1: active-low CPU interrupt.

## Operation
- **State.** `addr[13:0]`, `rbuf[7:0]`, `latch[7:0]`, `second` (control byte flag), `F` (frame flag), `reg[0..7][7:0]`.
- **Control write, `second=0`.**
  - `latch <= cpu_din`.
  - `second <= 1`.
- **Control write, `second=1`.** Always ends with `second <= 0`.
  - If `cpu_din[7]=1`: `reg[cpu_din[2:0]] <= latch`.
  - Else: `addr <= {cpu_din[5:0], latch}`.
  - If `cpu_din[7:6]=00`: also start a READ prefetch.
- **Data write.**
  - VRAM write `addr ← cpu_din`.
  - `rbuf <= cpu_din`.
  - `addr++`.
  - `second <= 0`.
- **Data read.**
  - `cpu_dout <= rbuf`.
  - Then start a READ prefetch.
  - `second <= 0`.
- **Status read.**
  - `cpu_dout <= {F,7'b0}`.
  - `F <= 0`.
  - `second <= 0`.
- **`F` set.** `F` is set on a rising edge of `frame_int`. Set has priority over clear in the same cycle. The returned status byte is the pre-update value.
- **Derived outputs.**
  - `video_on = reg1[6]`.
  - `n_int = ~(F & reg1[5])`.
  - `name_table_addr = {reg2[3:0],10'b0}`.
  - `font_addr = {reg4[2:0],11'b0}`.
  - `mode`: `M1=reg1[4]`, `M2=reg1[3]`, `M3=reg0[1]`. If `M1` then 0 (text 40-col); else if `M2` then 2; else if `M3` then 3; else 1 (graphics I).
- **Address arithmetic.** `addr` is modulo 2^14; `3FFF+1 = 0000`.
- **FSM.**
  - IDLE → WR (data write) → IDLE.
  - IDLE → RD_ISSUE → RD_WAIT → IDLE (prefetch).
  - `busy = (state != IDLE)`.
- **Strobes while busy.** A strobe arriving while `busy` is ignored entirely: no state change and no output change. The CPU interface guarantees ≥4 cycles between strobes.
- **Simultaneous strobes.** `cpu_wr` and `cpu_rd` together: `cpu_wr` wins.
- **Reset values.**
  - All registers, `addr`, `rbuf`, `latch`, `second`, `F`, `cpu_dout` are 0.
  - `vram_wr=0`, `vram_rd=0`, `busy=0`, `n_int=1`.
  - Derived: `mode=1`, `video_on=0`.
  - Reset in any state returns to IDLE in the same edge.

## Timing
- **Data write.** Strobe at edge 0. Edge 1: state WR, `vram_wr=1`, `vram_addr=addr`, `vram_din=data` (registered). Edge 2: `vram_wr=0`, `addr++`, IDLE.
- **Prefetch.** Edge 1: RD_ISSUE, `vram_rd=1`, `vram_addr=addr`. Edge 2: RD_WAIT, `vram_rd=0`. Edge 3: `rbuf <= vram_dout`, `addr++`, IDLE.
- **`cpu_dout`.** Updated on the edge following `cpu_rd`. It holds until the next read.
- **Register and `F` effects.** Register writes take effect 1 cycle after the second control strobe. `n_int` falls 1 cycle after the `frame_int` rising edge when IE=1.

## Structure
- **`vdp_pkg`.**
  - FSM state enum (IDLE, WR, RD_ISSUE, RD_WAIT).
  - Register index constants.
  - Bit positions (`BL=6`, `IE=5`, `M1=4`, `M2=3`, `M3=1`).
  - Mode encodings (`MODE_TEXT=0`, `MODE_G1=1`, `MODE_G2=2`, `MODE_MC=3`).
- **`vdp_regs` sub-module.** Holds the 8×8 register file, the write decode, and the derived configuration outputs (`mode`, table bases, `video_on`, IE). `vdp_ctrl` keeps the port decode, the FSM, `addr`/`rbuf`/`latch`/`second`/`F`.

## Test plan
- **Address set + data writes.** Control writes 0x00, 0x40, then data writes AA, BB → `vram_wr` at addr 0000=AA, 0001=BB; `addr`=0002.
- **Read-ahead.** Preload 0x1234=5A, 0x1235=C3. Control writes 0x34, 0x12 (read setup) → prefetch; data reads return 5A then C3; `addr`=0x1237.
- **Register write.** Control writes 0x70, 0x81 → reg1=70: `video_on=1`, IE=1, `mode=0`. Then 0x06, 0x82 → `name_table_addr=0x1800`. Then 0x03, 0x84 → `font_addr=0x1800`.
- **Interrupt.** With IE=1, pulse `frame_int` → `n_int=0` next cycle. Status read returns 0x80, `n_int=1`. A `frame_int` edge coincident with a status read leaves `F=1`.
- **Wrap and `second` reset.** Set addr 3FFF, write 2 bytes → writes at 3FFF then 0000. Single control write then status read → next control byte is treated as first.
- **Busy/reset.** Strobe during RD_WAIT is ignored. `reset` low during WR → next cycle IDLE, `vram_wr=0`, `mode=1`, `n_int=1`.

Source files
------------

// File: rtl/vdp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdp_pkg
// Description : Shared types and constants for the MSX VDP CPU controller:
//               FSM state encoding, register indices, register bit positions
//               and display mode encodings, plus the mode decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vdp_pkg;

   // VRAM sequencer states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WR       = 2'd1,
      ST_RD_ISSUE = 2'd2,
      ST_RD_WAIT  = 2'd3
   } vdp_state_t;

   // Register indices that feed the video configuration
   localparam logic [2:0] C_REG_R0 = 3'd0;
   localparam logic [2:0] C_REG_R1 = 3'd1;
   localparam logic [2:0] C_REG_R2 = 3'd2;
   localparam logic [2:0] C_REG_R4 = 3'd4;

   // Bit positions inside R0/R1
   localparam int C_BIT_BL = 6;
   localparam int C_BIT_IE = 5;
   localparam int C_BIT_M1 = 4;
   localparam int C_BIT_M2 = 3;
   localparam int C_BIT_M3 = 1;

   // Display mode encodings driven to the video block
   localparam logic [1:0] C_MODE_TEXT = 2'd0;
   localparam logic [1:0] C_MODE_G1   = 2'd1;
   localparam logic [1:0] C_MODE_G2   = 2'd2;
   localparam logic [1:0] C_MODE_MC   = 2'd3;

   // M1 has priority over M2, M2 over M3; none set selects graphics I
   function automatic logic [1:0] decode_mode(input logic m1, input logic m2,
                                              input logic m3);
      if (m1)      return C_MODE_TEXT;
      else if (m2) return C_MODE_G2;
      else if (m3) return C_MODE_MC;
      else         return C_MODE_G1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vdp_regs.sv
`default_nettype none
// ============================================================================
// Module      : vdp_regs
// Description : VDP register file R0..R7 with write port and the derived
//               video configuration outputs.
// Ports       : clk, reset (sync, active-low)
//               i_wr_en/i_wr_idx/i_wr_data - register write port
//               o_mode, o_name_table_addr, o_font_addr, o_video_on, o_int_en
// Revision    : 1.0 - initial release
// ============================================================================
import vdp_pkg::*;

module vdp_regs (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_wr_en,
   input  logic [2:0]  i_wr_idx,
   input  logic [7:0]  i_wr_data,
   output logic [1:0]  o_mode,
   output logic [13:0] o_name_table_addr,
   output logic [13:0] o_font_addr,
   output logic        o_video_on,
   output logic        o_int_en
);

   logic [7:0] r_regs [8];
   logic       w_unused_bits;

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) r_regs[i] <= 8'h00;
      end else if (i_wr_en) begin
         r_regs[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_video_on        = r_regs[C_REG_R1][C_BIT_BL];
   assign o_int_en          = r_regs[C_REG_R1][C_BIT_IE];
   assign o_name_table_addr = {r_regs[C_REG_R2][3:0], 10'b0};
   assign o_font_addr       = {r_regs[C_REG_R4][2:0], 11'b0};
   assign o_mode            = decode_mode(r_regs[C_REG_R1][C_BIT_M1],
                                          r_regs[C_REG_R1][C_BIT_M2],
                                          r_regs[C_REG_R0][C_BIT_M3]);

   // Registers/bits stored for CPU completeness but not consumed here
   assign w_unused_bits = ^{r_regs[0][7:2], r_regs[0][0], r_regs[1][7],
                            r_regs[1][2:0], r_regs[2][7:4], r_regs[3],
                            r_regs[4][7:3], r_regs[5], r_regs[6], r_regs[7]};

endmodule
`default_nettype wire

// File: rtl/vdp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vdp_ctrl
// Description : CPU-side controller for the MSX video subsystem. Decodes the
//               data/control ports, sequences VRAM port A accesses with
//               auto-increment and read-ahead, keeps the frame flag and
//               drives the CPU interrupt.
// Ports       : clk, reset (sync, active-low)
//               cpu_wr/cpu_rd/cpu_port/cpu_din/cpu_dout/busy - CPU side
//               vram_addr/vram_din/vram_wr/vram_rd/vram_dout - VRAM port A
//               frame_int - vblank in; n_int - active-low interrupt out
//               mode/name_table_addr/font_addr/video_on - video config
// Revision    : 1.0 - initial release
// ============================================================================
import vdp_pkg::*;

module vdp_ctrl #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_wr,
   input  logic              cpu_rd,
   input  logic              cpu_port,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   output logic              busy,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [7:0]        vram_din,
   output logic              vram_wr,
   output logic              vram_rd,
   input  logic [7:0]        vram_dout,
   input  logic              frame_int,
   output logic [1:0]        mode,
   output logic [13:0]       name_table_addr,
   output logic [13:0]       font_addr,
   output logic              video_on,
   output logic              n_int
);

   vdp_state_t        r_state, w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_rbuf, r_latch, r_cpu_dout, r_vram_din;
   logic              r_second, r_f, r_frame_d;

   logic w_idle, w_wr_acc, w_rd_acc;
   logic w_ctl_wr, w_data_wr, w_data_rd, w_stat_rd;
   logic w_ctl_second, w_reg_wr, w_prefetch, w_frame_rise, w_int_en;

   // Strobes are only honoured in IDLE; write wins over a coincident read
   assign w_idle       = (r_state == ST_IDLE);
   assign w_wr_acc     = cpu_wr & w_idle;
   assign w_rd_acc     = cpu_rd & ~cpu_wr & w_idle;
   assign w_ctl_wr     = w_wr_acc & cpu_port;
   assign w_data_wr    = w_wr_acc & ~cpu_port;
   assign w_data_rd    = w_rd_acc & ~cpu_port;
   assign w_stat_rd    = w_rd_acc & cpu_port;
   assign w_ctl_second = w_ctl_wr & r_second;
   assign w_reg_wr     = w_ctl_second & cpu_din[7];
   assign w_prefetch   = (w_ctl_second & (cpu_din[7:6] == 2'b00)) | w_data_rd;
   assign w_frame_rise = frame_int & ~r_frame_d;

   always_ff @(posedge clk) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      busy    = 1'b1;
      vram_wr = 1'b0;
      vram_rd = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (w_data_wr)       w_next = ST_WR;
            else if (w_prefetch) w_next = ST_RD_ISSUE;
         end
         ST_WR: begin
            vram_wr = 1'b1;
            w_next  = ST_IDLE;
         end
         ST_RD_ISSUE: begin
            vram_rd = 1'b1;
            w_next  = ST_RD_WAIT;
         end
         ST_RD_WAIT: w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_addr     <= '0;
         r_rbuf     <= 8'h00;
         r_latch    <= 8'h00;
         r_cpu_dout <= 8'h00;
         r_vram_din <= 8'h00;
         r_second   <= 1'b0;
         r_f        <= 1'b0;
         r_frame_d  <= 1'b0;
      end else begin
         r_frame_d <= frame_int;
         // A new vblank edge beats the status-read clear
         if (w_frame_rise)   r_f <= 1'b1;
         else if (w_stat_rd) r_f <= 1'b0;

         if (w_ctl_wr) begin
            if (!r_second) begin
               r_latch  <= cpu_din;
               r_second <= 1'b1;
            end else begin
               r_second <= 1'b0;
               if (!cpu_din[7]) r_addr <= ADDR_W'({cpu_din[5:0], r_latch});
            end
         end
         if (w_data_wr) begin
            r_vram_din <= cpu_din;
            r_rbuf     <= cpu_din;
            r_second   <= 1'b0;
         end
         if (w_data_rd) begin
            r_cpu_dout <= r_rbuf;
            r_second   <= 1'b0;
         end
         if (w_stat_rd) begin
            r_cpu_dout <= {r_f, 7'b0};
            r_second   <= 1'b0;
         end

         // Address advances as each VRAM access completes
         if (r_state == ST_WR || r_state == ST_RD_WAIT) r_addr <= r_addr + ADDR_W'(1);
         if (r_state == ST_RD_WAIT) r_rbuf <= vram_dout;
      end
   end

   vdp_regs u_regs (
      .clk               (clk),
      .reset             (reset),
      .i_wr_en           (w_reg_wr),
      .i_wr_idx          (cpu_din[2:0]),
      .i_wr_data         (r_latch),
      .o_mode            (mode),
      .o_name_table_addr (name_table_addr),
      .o_font_addr       (font_addr),
      .o_video_on        (video_on),
      .o_int_en          (w_int_en)
   );

   assign cpu_dout  = r_cpu_dout;
   assign vram_addr = r_addr;
   assign vram_din  = r_vram_din;
   assign n_int     = ~(r_f & w_int_en);

endmodule
`default_nettype wire

// File: tb/tb_vdp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdp_ctrl
// Description : Self-checking bench for vdp_ctrl with a 1-cycle-latency VRAM
//               model and scoreboard queues for VRAM writes and CPU reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdp_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_wr = 1'b0, cpu_rd = 1'b0, cpu_port = 1'b0;
   logic [7:0]  cpu_din = 8'h00;
   logic [7:0]  cpu_dout;
   logic        busy;
   logic [13:0] vram_addr;
   logic [7:0]  vram_din;
   logic        vram_wr, vram_rd;
   logic [7:0]  vram_dout = 8'h00;
   logic        frame_int = 1'b0;
   logic [1:0]  mode;
   logic [13:0] name_table_addr, font_addr;
   logic        video_on, n_int;

   typedef struct packed {
      logic [13:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t        exp_wr[$];
   logic [7:0] exp_rd[$];
   logic [7:0] mem [0:16383];
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   vdp_ctrl #(.ADDR_W(14)) dut (
      .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
      .cpu_port(cpu_port), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .busy(busy),
      .vram_addr(vram_addr), .vram_din(vram_din), .vram_wr(vram_wr),
      .vram_rd(vram_rd), .vram_dout(vram_dout), .frame_int(frame_int),
      .mode(mode), .name_table_addr(name_table_addr), .font_addr(font_addr),
      .video_on(video_on), .n_int(n_int)
   );

   // VRAM port A model: read data valid one cycle after vram_rd
   always @(posedge clk) begin
      if (vram_wr) mem[vram_addr] <= vram_din;
      if (vram_rd) vram_dout <= mem[vram_addr];
   end

   // Write scoreboard: every VRAM write cycle must match the next expected one
   always @(negedge clk) begin
      if (vram_wr) begin
         wr_t e;
         n_checks++;
         if (exp_wr.size() == 0) begin
            n_fail++;
            $display("FAIL vram_write: unexpected write addr=%h data=%h, none required",
                     vram_addr, vram_din);
         end else begin
            e = exp_wr.pop_front();
            if ({vram_addr, vram_din} !== {e.a, e.d}) begin
               n_fail++;
               $display("FAIL vram_write: got addr=%h data=%h, required addr=%h data=%h",
                        vram_addr, vram_din, e.a, e.d);
            end
         end
      end
   end

   task automatic cpu_write(input logic port, input logic [7:0] data);
      @(negedge clk); cpu_port = port; cpu_din = data; cpu_wr = 1'b1;
      @(negedge clk); cpu_wr = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cpu_read(input logic port, output logic [7:0] data);
      @(negedge clk); cpu_port = port; cpu_rd = 1'b1;
      @(negedge clk); cpu_rd = 1'b0; data = cpu_dout;
      repeat (4) @(negedge clk);
   endtask

   task automatic push_wr(input logic [13:0] a, input logic [7:0] d);
      wr_t e;
      e.a = a; e.d = d;
      exp_wr.push_back(e);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({cpu_dout, busy, vram_wr, vram_rd, n_int, mode, video_on} !==
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_outputs: dout=%h busy=%b wr=%b rd=%b n_int=%b mode=%0d von=%b, required 00 0 0 0 1 1 0",
                  cpu_dout, busy, vram_wr, vram_rd, n_int, mode, video_on);
      end
      n_checks++;
      if ({name_table_addr, font_addr} !== 28'h0) begin
         n_fail++;
         $display("FAIL reset_tables: name=%h font=%h, required 0000 0000", name_table_addr, font_addr);
      end
   endtask

   task automatic test_addr_write;
      cpu_write(1'b1, 8'h00);
      cpu_write(1'b1, 8'h40);
      push_wr(14'h0000, 8'hAA);
      @(negedge clk); cpu_port = 1'b0; cpu_din = 8'hAA; cpu_wr = 1'b1;
      @(negedge clk); cpu_wr = 1'b0;
      n_checks++;
      if ({vram_wr, busy, vram_addr, vram_din} !== {1'b1, 1'b1, 14'h0000, 8'hAA}) begin
         n_fail++;
         $display("FAIL write_edge1: wr=%b busy=%b addr=%h din=%h, required 1 1 0000 AA",
                  vram_wr, busy, vram_addr, vram_din);
      end
      @(negedge clk);
      n_checks++;
      if ({vram_wr, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL write_edge2: wr=%b busy=%b, required 0 0", vram_wr, busy);
      end
      repeat (3) @(negedge clk);
      push_wr(14'h0001, 8'hBB);
      cpu_write(1'b0, 8'hBB);
      push_wr(14'h0002, 8'h01);       // proves addr reached 0002
      cpu_write(1'b0, 8'h01);
   endtask

   task automatic test_read_ahead;
      logic [7:0] got, exp;
      cpu_write(1'b1, 8'h34);
      cpu_write(1'b1, 8'h52);         // write setup at 1234
      push_wr(14'h1234, 8'h5A); cpu_write(1'b0, 8'h5A);
      push_wr(14'h1235, 8'hC3); cpu_write(1'b0, 8'hC3);
      cpu_write(1'b1, 8'h34);
      @(negedge clk); cpu_port = 1'b1; cpu_din = 8'h12; cpu_wr = 1'b1;
      @(negedge clk); cpu_wr = 1'b0;
      n_checks++;
      if ({vram_rd, busy, vram_addr} !== {1'b1, 1'b1, 14'h1234}) begin
         n_fail++;
         $display("FAIL prefetch_issue: rd=%b busy=%b addr=%h, required 1 1 1234", vram_rd, busy, vram_addr);
      end
      @(negedge clk);
      n_checks++;
      if ({vram_rd, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL prefetch_wait: rd=%b busy=%b, required 0 1", vram_rd, busy);
      end
      repeat (3) @(negedge clk);
      exp_rd.push_back(8'h5A);
      exp_rd.push_back(8'hC3);
      for (int i = 0; i < 2; i++) begin
         cpu_read(1'b0, got);
         exp = exp_rd.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL data_read%0d: got %h, required %h", i, got, exp);
         end
      end
      push_wr(14'h1237, 8'h3C);       // proves addr reached 1237
      cpu_write(1'b0, 8'h3C);
   endtask

   task automatic test_regs;
      cpu_write(1'b1, 8'h02); cpu_write(1'b1, 8'h80);
      n_checks++;
      if (mode !== 2'd3) begin
         n_fail++; $display("FAIL mode_m3: got %0d, required 3", mode);
      end
      cpu_write(1'b1, 8'h08); cpu_write(1'b1, 8'h81);
      n_checks++;
      if ({mode, video_on} !== {2'd2, 1'b0}) begin
         n_fail++; $display("FAIL mode_m2: mode=%0d von=%b, required 2 0", mode, video_on);
      end
      cpu_write(1'b1, 8'h70);
      @(negedge clk); cpu_port = 1'b1; cpu_din = 8'h81; cpu_wr = 1'b1;
      @(negedge clk); cpu_wr = 1'b0;
      n_checks++;
      if ({mode, video_on, n_int, busy} !== {2'd0, 1'b1, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reg1_write: mode=%0d von=%b n_int=%b busy=%b, required 0 1 1 0",
                  mode, video_on, n_int, busy);
      end
      repeat (4) @(negedge clk);
      cpu_write(1'b1, 8'h06); cpu_write(1'b1, 8'h82);
      n_checks++;
      if (name_table_addr !== 14'h1800) begin
         n_fail++; $display("FAIL name_table: got %h, required 1800", name_table_addr);
      end
      cpu_write(1'b1, 8'h03); cpu_write(1'b1, 8'h84);
      n_checks++;
      if (font_addr !== 14'h1800) begin
         n_fail++; $display("FAIL font_addr: got %h, required 1800", font_addr);
      end
   endtask

   task automatic test_interrupt;
      logic [7:0] got, exp;
      @(negedge clk); frame_int = 1'b1;
      @(negedge clk);
      n_checks++;
      if (n_int !== 1'b0) begin
         n_fail++; $display("FAIL int_assert: n_int=%b, required 0", n_int);
      end
      repeat (2) @(negedge clk);
      frame_int = 1'b0;
      exp_rd.push_back(8'h80);
      cpu_read(1'b1, got);
      exp = exp_rd.pop_front();
      n_checks++;
      if ({got, n_int} !== {exp, 1'b1}) begin
         n_fail++; $display("FAIL status_read: got %h n_int=%b, required %h 1", got, n_int, exp);
      end
      // vblank edge in the same cycle as a status read
      exp_rd.push_back(8'h00);
      @(negedge clk); cpu_port = 1'b1; cpu_rd = 1'b1; frame_int = 1'b1;
      @(negedge clk); cpu_rd = 1'b0; got = cpu_dout;
      exp = exp_rd.pop_front();
      n_checks++;
      if ({got, n_int} !== {exp, 1'b0}) begin
         n_fail++; $display("FAIL status_coincident: got %h n_int=%b, required %h 0", got, n_int, exp);
      end
      frame_int = 1'b0;
      repeat (4) @(negedge clk);
      exp_rd.push_back(8'h80);
      cpu_read(1'b1, got);
      exp = exp_rd.pop_front();
      n_checks++;
      if (got !== exp) begin
         n_fail++; $display("FAIL status_after_coincident: got %h, required %h", got, exp);
      end
   endtask

   task automatic test_wrap_second;
      logic [7:0] got;
      cpu_write(1'b1, 8'hFF); cpu_write(1'b1, 8'h7F);
      push_wr(14'h3FFF, 8'hCC); cpu_write(1'b0, 8'hCC);
      push_wr(14'h0000, 8'hDD); cpu_write(1'b0, 8'hDD);
      cpu_write(1'b1, 8'h00);         // lone first byte
      cpu_read(1'b1, got);            // status read drops the half-written pair
      cpu_write(1'b1, 8'h55); cpu_write(1'b1, 8'h40);
      push_wr(14'h0055, 8'hEE); cpu_write(1'b0, 8'hEE);
      // write and read together: the write must win
      push_wr(14'h0056, 8'h12);
      @(negedge clk); cpu_port = 1'b0; cpu_din = 8'h12; cpu_wr = 1'b1; cpu_rd = 1'b1;
      @(negedge clk); cpu_wr = 1'b0; cpu_rd = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++;
      if (cpu_dout !== got) begin
         n_fail++; $display("FAIL wr_rd_priority: cpu_dout=%h, required %h", cpu_dout, got);
      end
   endtask

   task automatic test_busy_reset;
      logic [7:0] got, exp;
      cpu_write(1'b1, 8'h01);
      @(negedge clk); cpu_port = 1'b1; cpu_din = 8'h00; cpu_wr = 1'b1;
      @(negedge clk); cpu_wr = 1'b0;   // RD_ISSUE
      @(negedge clk);                  // RD_WAIT: this strobe must be ignored
      cpu_port = 1'b0; cpu_din = 8'h99; cpu_wr = 1'b1;
      @(negedge clk); cpu_wr = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL busy_release: busy=%b, required 0", busy);
      end
      repeat (3) @(negedge clk);
      exp_rd.push_back(8'hBB);
      cpu_read(1'b0, got);
      exp = exp_rd.pop_front();
      n_checks++;
      if (got !== exp) begin
         n_fail++; $display("FAIL busy_ignored: read %h, required %h", got, exp);
      end
      push_wr(14'h0003, 8'h77);
      @(negedge clk); cpu_port = 1'b0; cpu_din = 8'h77; cpu_wr = 1'b1;
      @(negedge clk); cpu_wr = 1'b0; reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({vram_wr, busy, mode, n_int, video_on, cpu_dout} !==
          {1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_in_wr: wr=%b busy=%b mode=%0d n_int=%b von=%b dout=%h, required 0 0 1 1 0 00",
                  vram_wr, busy, mode, n_int, video_on, cpu_dout);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_addr_write();
      test_read_ahead();
      test_regs();
      test_interrupt();
      test_wrap_second();
      test_busy_reset();
      n_checks++;
      if (exp_wr.size() != 0) begin
         n_fail++;
         $display("FAIL missing_writes: %0d expected writes never seen, required 0", exp_wr.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
